axi_r_tap_stream: RTL and testbench
===================================

# axi_r_tap_stream

AXI read-data-channel tap sitting between an AXI master port (AXIM_r*) and slave port (AXIS_r*) in the EthHelper datapath. Forwards every R beat unchanged and copies beats of selected bursts into an internal FIFO. The FIFO drains as a framed side stream (valid/ready/last/data) for the Ethernet packetiser. Per-burst bookkeeping (in_progress, transaction length, truncation) is exported for the packet-header logic.

## Interface
- DATA_WIDTH, 128: R data width; also side-stream data width.
- ID_WIDTH, 32: rid width.
- USER_WIDTH, 64: ruser width.
- FIFO_DEPTH, 16: tap FIFO entries; power of two, ≥4.
- DROP_ON_FULL, 0: 0 = lossless (tap backpressures R channel); 1 = never stall R channel, truncate tapped burst instead.
- clk  in  1  sole clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- AXIM_rid / AXIM_rdata / AXIM_rresp / AXIM_rlast / AXIM_ruser / AXIM_rvalid  in  ID_WIDTH / DATA_WIDTH / 2 / 1 / USER_WIDTH / 1  upstream R channel.
- AXIM_rready  out  1  upstream ready.
- AXIS_rid / AXIS_rdata / AXIS_rresp / AXIS_rlast / AXIS_ruser / AXIS_rvalid  out  same widths  downstream R channel.
- AXIS_rready  in  1  downstream ready.
- tap_enable  in  1  capture request, sampled only on the first beat of a burst.
- valid  out  1  side-stream beat valid.
- ready  in  1  side-stream consumer ready.
- data  out  DATA_WIDTH  side-stream beat data.
- last  out  1  final beat of a tapped burst.
- in_progress  out  1  a tapped burst is being captured or still held in the FIFO.
- submodule_transaction_length  out  6  beat count of the last completed tapped burst, saturating at 63.
- tap_truncated  out  1  one-cycle pulse when a tapped burst is cut short (DROP_ON_FULL=1 only).

## Operation
- R fields rid/rdata/rresp/rlast/ruser pass combinationally AXIM→AXIS.
- Handshake gating:
  - Lossless: AXIS_rvalid = AXIM_rvalid & ~stall; AXIM_rready = AXIS_rready & ~stall; stall = (state==CAPTURE or first beat with tap_enable) & fifo_full.
  - Drop mode: stall is tied 0.
- A beat is transferred ("fire") when AXIM_rvalid & AXIM_rready.
- First-beat flag: set by reset and by any fire with rlast; cleared by any other fire.
- FSM states: IDLE, CAPTURE, SKIP.
  - IDLE, fire on first beat: tap_enable=1 → write beat, go CAPTURE (stay IDLE if rlast); tap_enable=0 → go SKIP (stay IDLE if rlast).
  - CAPTURE, fire: write beat; on rlast go IDLE.
  - SKIP, fire: no write; on rlast go IDLE.
- FIFO entry = {data, last}; entry last = AXIM_rlast.
- Drop mode, one free entry left on a CAPTURE write with rlast=0:
  - store the beat with last forced to 1;
  - pulse tap_truncated;
  - go SKIP; rest of burst is forwarded but not tapped.
- Drop mode, full FIFO on the first beat: burst is not tapped (SKIP), no pulse.
- Beat counter increments per write and clears on each first-beat write. When the written entry has last=1, submodule_transaction_length ← min(count incl. this beat, 63).
- in_progress = (state==CAPTURE) | ~fifo_empty.
- Side stream: valid = ~fifo_empty; pop when valid & ready; data/last show the head entry.

## Timing
- Forward path: zero latency, purely combinational.
- Tap latency: a beat written at edge N is visible on valid/data at N+1.
- Throughput: one write and one pop per cycle.
- FIFO full: full is evaluated before any same-cycle pop, so a full FIFO blocks the write even if a pop occurs that cycle.
- Side-stream rule: valid never drops without ready; data/last stable while valid & ~ready.
- Reset values, applied on the clk edge where reset=1:
  - FSM = IDLE; first-beat flag = 1; FIFO empty.
  - valid, last, data, in_progress, tap_truncated = 0; submodule_transaction_length = 0.
- Reset mid-burst discards FIFO contents and partial-burst state. The next fired beat is treated as a first beat.
- Reset does not gate the combinational forward path.

## Structure
- Package axi_tap_pkg holds:
  - tap_state_e enum (IDLE, CAPTURE, SKIP);
  - LEN_W = 6 and LEN_SAT = 63;
  - function clog2-based FIFO_AW derivation.
- Sub-module axi_r_tap_fifo: synchronous FIFO, first-word fall-through, parameters WIDTH and DEPTH, ports wr_en/wr_data/rd_en/rd_data/full/empty/almost_full (one entry free). Pointers are AW+1 bits with wrap bit.

## Test plan
- Lossless, FIFO_DEPTH=16, tap_enable=1, 4-beat burst, ready=1 → 4 beats forwarded with no stall. Side stream shows the same data one cycle later, last on beat 4, submodule_transaction_length=4, in_progress falls after the last pop.
- tap_enable=0 on first beat, raised mid-burst → burst forwarded, nothing tapped, valid stays 0.
- Lossless, ready=0, 20-beat burst → 16 beats pass, then AXIM_rready=0 and AXIS_rvalid=0. Releasing ready resumes; all 20 tapped beats arrive in order.
- DROP_ON_FULL=1, ready=0, 20-beat burst → AXIM_rready never drops. 16 entries stored, entry 16 has last=1, tap_truncated pulses once, length=16.
- 70-beat burst, ready=1 → length saturates at 63; next 2-beat burst reports 2.
- Reset asserted at beat 3 of 8 with FIFO non-empty → next cycle valid=0 and in_progress=0. The following burst taps correctly from its first fired beat.

Source files
------------

// File: rtl/axi_tap_pkg.sv
// -----------------------------------------------------------------------------
// axi_tap_pkg
// Shared types and constants for the AXI R-channel tap:
//   tap_state_e : burst tracking states (IDLE, CAPTURE, SKIP)
//   LEN_W       : width of the exported burst length
//   LEN_SAT     : saturation value of the burst length
//   fifo_aw()   : address width of a tap FIFO of a given depth
// -----------------------------------------------------------------------------
package axi_tap_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      SKIP    = 2'd2
   } tap_state_e;

   localparam int LEN_W   = 6;
   localparam int LEN_SAT = 63;

   // Address width for a power-of-two FIFO; a depth of 1 still needs one bit.
   function automatic int fifo_aw(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/axi_r_tap_fifo.sv
// -----------------------------------------------------------------------------
// axi_r_tap_fifo
// Synchronous first-word-fall-through FIFO holding tapped R beats.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (empties the FIFO)
//   wr_en, wr_data  : write request and entry; ignored while full
//   rd_en, rd_data  : pop request; rd_data always shows the head entry
//   full, empty     : occupancy flags, both derived from registered pointers
//   almost_full     : exactly one entry free
// Pointers carry an extra wrap bit so full and empty are distinguishable.
// -----------------------------------------------------------------------------
module axi_r_tap_fifo
   import axi_tap_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic             almost_full
);

   localparam int AW = fifo_aw(DEPTH);
   localparam logic [AW:0] C_FULL  = (AW+1)'(DEPTH);
   localparam logic [AW:0] C_AFULL = (AW+1)'(DEPTH - 1);
   localparam logic [AW:0] C_ONE   = (AW+1)'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [AW:0]      w_count;
   logic             w_do_wr;
   logic             w_do_rd;

   assign w_count     = r_wr_ptr - r_rd_ptr;
   assign full        = (w_count == C_FULL);
   assign empty       = (r_wr_ptr == r_rd_ptr);
   assign almost_full = (w_count == C_AFULL);

   // Full is judged before any same-cycle pop, so a pop never frees room early.
   assign w_do_wr = wr_en & ~full;
   assign w_do_rd = rd_en & ~empty;
   assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

   // Storage array; validity is tracked by the pointers, so no reset is needed.
   always_ff @(posedge clk) begin
      if (w_do_wr) begin
         r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   // Read and write pointer update.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_wr) begin
            r_wr_ptr <= r_wr_ptr + C_ONE;
         end
         if (w_do_rd) begin
            r_rd_ptr <= r_rd_ptr + C_ONE;
         end
      end
   end

endmodule

// File: rtl/axi_r_tap_stream.sv
// -----------------------------------------------------------------------------
// axi_r_tap_stream
// AXI read-data tap: forwards every R beat from AXIM_r* to AXIS_r* with zero
// latency and copies the beats of selected bursts into a FIFO that drains as a
// framed side stream.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   AXIM_r* (in) / AXIM_rready     : upstream R channel
//   AXIS_r* (out) / AXIS_rready    : downstream R channel
//   tap_enable                     : capture request, looked at on first beats
//   valid/ready/data/last          : side stream of tapped beats
//   in_progress                    : tapped burst being captured or still queued
//   submodule_transaction_length   : beats of last completed tapped burst (sat.)
//   tap_truncated                  : one-cycle pulse when a tapped burst is cut
// DROP_ON_FULL=0 stalls the R channel when the FIFO is full; DROP_ON_FULL=1
// never stalls and instead closes the tapped burst early.
// -----------------------------------------------------------------------------
module axi_r_tap_stream
   import axi_tap_pkg::*;
#(
   parameter int DATA_WIDTH   = 128,
   parameter int ID_WIDTH     = 32,
   parameter int USER_WIDTH   = 64,
   parameter int FIFO_DEPTH   = 16,
   parameter int DROP_ON_FULL = 0
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ID_WIDTH-1:0]   AXIM_rid,
   input  logic [DATA_WIDTH-1:0] AXIM_rdata,
   input  logic [1:0]            AXIM_rresp,
   input  logic                  AXIM_rlast,
   input  logic [USER_WIDTH-1:0] AXIM_ruser,
   input  logic                  AXIM_rvalid,
   output logic                  AXIM_rready,
   output logic [ID_WIDTH-1:0]   AXIS_rid,
   output logic [DATA_WIDTH-1:0] AXIS_rdata,
   output logic [1:0]            AXIS_rresp,
   output logic                  AXIS_rlast,
   output logic [USER_WIDTH-1:0] AXIS_ruser,
   output logic                  AXIS_rvalid,
   input  logic                  AXIS_rready,
   input  logic                  tap_enable,
   output logic                  valid,
   input  logic                  ready,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  last,
   output logic                  in_progress,
   output logic [LEN_W-1:0]      submodule_transaction_length,
   output logic                  tap_truncated
);

   localparam bit               C_DROP    = (DROP_ON_FULL != 0);
   localparam logic [LEN_W-1:0] C_LEN_ONE = LEN_W'(1);
   localparam logic [LEN_W-1:0] C_LEN_SAT = LEN_W'(LEN_SAT);

   tap_state_e          r_state;
   logic                r_first;
   logic                r_trunc;
   logic [LEN_W-1:0]    r_cnt;
   logic [LEN_W-1:0]    r_len;

   logic                w_fire;
   logic                w_first_tap;
   logic                w_want_tap;
   logic                w_stall;
   logic                w_wr_en;
   logic                w_trunc;
   logic                w_wr_last;
   logic                w_full;
   logic                w_empty;
   logic                w_afull;
   logic                w_pop;
   logic [LEN_W-1:0]    w_cnt_next;
   logic [DATA_WIDTH:0] w_rd_data;

   // Forward path: payload is passed straight through, reset does not gate it.
   assign AXIS_rid    = AXIM_rid;
   assign AXIS_rdata  = AXIM_rdata;
   assign AXIS_rresp  = AXIM_rresp;
   assign AXIS_rlast  = AXIM_rlast;
   assign AXIS_ruser  = AXIM_ruser;
   assign AXIS_rvalid = AXIM_rvalid & ~w_stall;
   assign AXIM_rready = AXIS_rready & ~w_stall;

   assign w_fire      = AXIM_rvalid & AXIM_rready;
   assign w_first_tap = (r_state == IDLE) & r_first & tap_enable;
   assign w_want_tap  = (r_state == CAPTURE) | w_first_tap;

   // Lossless mode holds the R channel while a wanted beat has nowhere to go.
   assign w_stall   = C_DROP ? 1'b0 : (w_want_tap & w_full);
   assign w_wr_en   = w_fire & w_want_tap & ~w_full;
   // Drop mode: the last free slot closes the burst so the frame stays well formed.
   assign w_trunc   = C_DROP & w_wr_en & w_afull & ~AXIM_rlast;
   assign w_wr_last = AXIM_rlast | w_trunc;

   // A write from IDLE is always the first beat of a burst and restarts the count.
   assign w_cnt_next = (r_state == IDLE) ? C_LEN_ONE :
                       ((r_cnt == C_LEN_SAT) ? r_cnt : (r_cnt + C_LEN_ONE));

   assign w_pop = ~w_empty & ready;

   axi_r_tap_fifo #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (w_wr_en),
      .wr_data     ({AXIM_rdata, w_wr_last}),
      .rd_en       (w_pop),
      .rd_data     (w_rd_data),
      .full        (w_full),
      .empty       (w_empty),
      .almost_full (w_afull)
   );

   // Burst tracking: state, first-beat flag, beat count, length and trunc pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_first <= 1'b1;
         r_cnt   <= '0;
         r_len   <= '0;
         r_trunc <= 1'b0;
      end else begin
         r_trunc <= w_trunc;
         if (w_fire) begin
            r_first <= AXIM_rlast;
         end
         if (w_wr_en) begin
            r_cnt <= w_cnt_next;
            if (w_wr_last) begin
               r_len <= w_cnt_next;
            end
         end
         case (r_state)
            IDLE: begin
               if (w_fire && r_first && !AXIM_rlast) begin
                  r_state <= (w_wr_en && !w_trunc) ? CAPTURE : SKIP;
               end
            end
            CAPTURE: begin
               if (w_fire) begin
                  if (AXIM_rlast) begin
                     r_state <= IDLE;
                  end else if (w_trunc) begin
                     r_state <= SKIP;
                  end
               end
            end
            SKIP: begin
               if (w_fire && AXIM_rlast) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Side stream shows the FIFO head; data and last read as zero when empty.
   assign valid       = ~w_empty;
   assign data        = w_empty ? '0 : w_rd_data[DATA_WIDTH:1];
   assign last        = ~w_empty & w_rd_data[0];
   assign in_progress = (r_state == CAPTURE) | ~w_empty;
   assign submodule_transaction_length = r_len;
   assign tap_truncated                = r_trunc;

endmodule

// File: tb/tb_axi_r_tap_stream.sv
// Directed bench for axi_r_tap_stream: one lossless and one drop-mode instance.
module tb_axi_r_tap_stream;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [31:0]  m_rid = '0;
   logic [127:0] m_rdata = '0;
   logic [1:0]   m_rresp = '0;
   logic         m_rlast = 1'b0;
   logic [63:0]  m_ruser = '0;
   logic         m_valid = 1'b0;
   logic         sel = 1'b0;          // 0 drives the lossless DUT, 1 the drop DUT
   logic         s_ready = 1'b1;
   logic         tap_en = 1'b0;
   logic         st_ready_ll = 1'b0;
   logic         st_ready_dr = 1'b0;

   logic         rvalid_ll, rvalid_dr, cur_rready;
   logic         rready_ll, svalid_ll, slast_ll, valid_ll, last_ll, inprog_ll, trunc_ll;
   logic         rready_dr, svalid_dr, slast_dr, valid_dr, last_dr, inprog_dr, trunc_dr;
   logic [31:0]  sid_ll, sid_dr;
   logic [127:0] sdata_ll, sdata_dr, data_ll, data_dr;
   logic [1:0]   sresp_ll, sresp_dr;
   logic [63:0]  suser_ll, suser_dr;
   logic [5:0]   len_ll, len_dr;

   int n_checks = 0;
   int n_pass = 0;
   int n_trunc = 0;
   logic [128:0] rx_ll[$];
   logic [128:0] rx_dr[$];

   assign rvalid_ll  = m_valid & ~sel;
   assign rvalid_dr  = m_valid & sel;
   assign cur_rready = sel ? rready_dr : rready_ll;

   always #5 clk = ~clk;

   axi_r_tap_stream #(.DATA_WIDTH(128), .ID_WIDTH(32), .USER_WIDTH(64),
                      .FIFO_DEPTH(16), .DROP_ON_FULL(0)) dut_ll (
      .clk(clk), .reset(reset),
      .AXIM_rid(m_rid), .AXIM_rdata(m_rdata), .AXIM_rresp(m_rresp), .AXIM_rlast(m_rlast),
      .AXIM_ruser(m_ruser), .AXIM_rvalid(rvalid_ll), .AXIM_rready(rready_ll),
      .AXIS_rid(sid_ll), .AXIS_rdata(sdata_ll), .AXIS_rresp(sresp_ll), .AXIS_rlast(slast_ll),
      .AXIS_ruser(suser_ll), .AXIS_rvalid(svalid_ll), .AXIS_rready(s_ready),
      .tap_enable(tap_en), .valid(valid_ll), .ready(st_ready_ll), .data(data_ll), .last(last_ll),
      .in_progress(inprog_ll), .submodule_transaction_length(len_ll), .tap_truncated(trunc_ll));

   axi_r_tap_stream #(.DATA_WIDTH(128), .ID_WIDTH(32), .USER_WIDTH(64),
                      .FIFO_DEPTH(16), .DROP_ON_FULL(1)) dut_dr (
      .clk(clk), .reset(reset),
      .AXIM_rid(m_rid), .AXIM_rdata(m_rdata), .AXIM_rresp(m_rresp), .AXIM_rlast(m_rlast),
      .AXIM_ruser(m_ruser), .AXIM_rvalid(rvalid_dr), .AXIM_rready(rready_dr),
      .AXIS_rid(sid_dr), .AXIS_rdata(sdata_dr), .AXIS_rresp(sresp_dr), .AXIS_rlast(slast_dr),
      .AXIS_ruser(suser_dr), .AXIS_rvalid(svalid_dr), .AXIS_rready(s_ready),
      .tap_enable(tap_en), .valid(valid_dr), .ready(st_ready_dr), .data(data_dr), .last(last_dr),
      .in_progress(inprog_dr), .submodule_transaction_length(len_dr), .tap_truncated(trunc_dr));

   function automatic logic [127:0] bdata(input int b, input int i);
      return {32'hC0DE0000 + 32'(b), 32'(i), ~32'(b * 64 + i), 32'(b * 1000 + i)};
   endfunction

   // Side-stream and truncation monitor, sampled just before each rising edge.
   always @(negedge clk) begin
      #4;
      if (valid_ll && st_ready_ll) rx_ll.push_back({data_ll, last_ll});
      if (valid_dr && st_ready_dr) rx_dr.push_back({data_dr, last_dr});
      if (trunc_dr) n_trunc++;
   end

   // Present beat i of burst b (n beats) until it fires or max_wait retries pass.
   task automatic put_beat(input int b, input int i, input int n, input logic te,
                           input int max_wait, output bit fired);
      int waits;
      m_rid = 32'(b); m_rdata = bdata(b, i); m_rresp = 2'(i); m_rlast = (i == n - 1);
      m_ruser = 64'(b * 256 + i); tap_en = te; m_valid = 1'b1;
      fired = 1'b0; waits = 0;
      while (!fired && waits <= max_wait) begin
         #1;
         if (cur_rready) begin
            fired = 1'b1;
            @(posedge clk);
         end else begin
            waits++;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1; sel = 1'b0; m_valid = 1'b1; m_rdata = bdata(0, 0); tap_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_checks++; if (valid_ll !== 1'b0) $display("FAIL rst_valid: got %0b want 0", valid_ll); else n_pass++;
      n_checks++; if (last_ll !== 1'b0) $display("FAIL rst_last: got %0b want 0", last_ll); else n_pass++;
      n_checks++; if (data_ll !== 128'd0) $display("FAIL rst_data: got %0h want 0", data_ll); else n_pass++;
      n_checks++; if (inprog_ll !== 1'b0) $display("FAIL rst_inprog: got %0b want 0", inprog_ll); else n_pass++;
      n_checks++; if (len_ll !== 6'd0) $display("FAIL rst_len: got %0d want 0", len_ll); else n_pass++;
      n_checks++; if (trunc_ll !== 1'b0) $display("FAIL rst_trunc: got %0b want 0", trunc_ll); else n_pass++;
      n_checks++; if (valid_dr !== 1'b0 || len_dr !== 6'd0) $display("FAIL rst_dr: got valid %0b len %0d want 0 0", valid_dr, len_dr); else n_pass++;
      n_checks++; if (svalid_ll !== 1'b1) $display("FAIL rst_fwd_valid: got %0b want 1", svalid_ll); else n_pass++;
      n_checks++; if (sdata_ll !== bdata(0, 0)) $display("FAIL rst_fwd_data: got %0h want %0h", sdata_ll, bdata(0, 0)); else n_pass++;
      n_checks++; if (rready_ll !== 1'b1) $display("FAIL rst_rready: got %0b want 1", rready_ll); else n_pass++;
      m_valid = 1'b0; reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic_tap();
      bit f;
      sel = 1'b0; st_ready_ll = 1'b1; rx_ll.delete();
      for (int i = 0; i < 4; i++) begin
         put_beat(1, i, 4, 1'b1, 0, f);
         n_checks++; if (f !== 1'b1) $display("FAIL basic_fire[%0d]: got %0b want 1", i, f); else n_pass++;
         n_checks++; if (valid_ll !== 1'b1) $display("FAIL basic_valid[%0d]: got %0b want 1", i, valid_ll); else n_pass++;
         n_checks++; if (data_ll !== bdata(1, i)) $display("FAIL basic_data[%0d]: got %0h want %0h", i, data_ll, bdata(1, i)); else n_pass++;
         n_checks++; if (last_ll !== (i == 3)) $display("FAIL basic_last[%0d]: got %0b want %0b", i, last_ll, (i == 3)); else n_pass++;
      end
      n_checks++; if (inprog_ll !== 1'b1) $display("FAIL basic_inprog_hi: got %0b want 1", inprog_ll); else n_pass++;
      n_checks++; if (len_ll !== 6'd4) $display("FAIL basic_len: got %0d want 4", len_ll); else n_pass++;
      m_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (valid_ll !== 1'b0) $display("FAIL basic_drain_valid: got %0b want 0", valid_ll); else n_pass++;
      n_checks++; if (inprog_ll !== 1'b0) $display("FAIL basic_inprog_lo: got %0b want 0", inprog_ll); else n_pass++;
      n_checks++; if (rx_ll.size() !== 4) $display("FAIL basic_popped: got %0d want 4", rx_ll.size()); else n_pass++;
   endtask

   task automatic test_no_tap();
      bit f;
      int fires;
      sel = 1'b0; st_ready_ll = 1'b1; rx_ll.delete(); fires = 0;
      for (int i = 0; i < 4; i++) begin
         put_beat(2, i, 4, (i > 0), 0, f);
         if (f) fires++;
         n_checks++; if ({sid_ll, sdata_ll, sresp_ll, slast_ll, suser_ll, svalid_ll} !==
                         {32'(2), bdata(2, i), 2'(i), (i == 3), 64'(2 * 256 + i), 1'b1})
            $display("FAIL notap_fwd[%0d]: got data %0h want %0h", i, sdata_ll, bdata(2, i)); else n_pass++;
         n_checks++; if (valid_ll !== 1'b0) $display("FAIL notap_valid[%0d]: got %0b want 0", i, valid_ll); else n_pass++;
      end
      m_valid = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (fires !== 4) $display("FAIL notap_fires: got %0d want 4", fires); else n_pass++;
      n_checks++; if (rx_ll.size() !== 0) $display("FAIL notap_rx: got %0d want 0", rx_ll.size()); else n_pass++;
      n_checks++; if (len_ll !== 6'd4 || inprog_ll !== 1'b0) $display("FAIL notap_state: got len %0d inprog %0b want 4 0", len_ll, inprog_ll); else n_pass++;
   endtask

   task automatic test_lossless_full();
      bit f;
      int fires, bad, t;
      sel = 1'b0; st_ready_ll = 1'b0; rx_ll.delete(); fires = 0; bad = 0; t = 0;
      for (int i = 0; i < 16; i++) begin
         put_beat(3, i, 20, 1'b1, 0, f);
         if (f) fires++;
      end
      n_checks++; if (fires !== 16) $display("FAIL full_first16: got %0d want 16", fires); else n_pass++;
      put_beat(3, 16, 20, 1'b1, 3, f);
      #1;
      n_checks++; if (f !== 1'b0) $display("FAIL full_stall_fire: got %0b want 0", f); else n_pass++;
      n_checks++; if (rready_ll !== 1'b0) $display("FAIL full_rready: got %0b want 0", rready_ll); else n_pass++;
      n_checks++; if (svalid_ll !== 1'b0) $display("FAIL full_svalid: got %0b want 0", svalid_ll); else n_pass++;
      n_checks++; if (valid_ll !== 1'b1 || data_ll !== bdata(3, 0)) $display("FAIL full_head: got %0h want %0h", data_ll, bdata(3, 0)); else n_pass++;
      n_checks++; if (inprog_ll !== 1'b1) $display("FAIL full_inprog: got %0b want 1", inprog_ll); else n_pass++;
      st_ready_ll = 1'b1; fires = 0;
      for (int i = 16; i < 20; i++) begin
         put_beat(3, i, 20, 1'b1, 50, f);
         if (f) fires++;
      end
      m_valid = 1'b0;
      while (rx_ll.size() < 20 && t < 60) begin @(negedge clk); t++; end
      repeat (2) @(negedge clk);
      for (int k = 0; k < rx_ll.size(); k++)
         if (rx_ll[k] !== {bdata(3, k), (k == 19)}) bad++;
      n_checks++; if (fires !== 4) $display("FAIL full_resume: got %0d want 4", fires); else n_pass++;
      n_checks++; if (rx_ll.size() !== 20) $display("FAIL full_count: got %0d want 20", rx_ll.size()); else n_pass++;
      n_checks++; if (bad !== 0) $display("FAIL full_order: got %0d bad entries want 0", bad); else n_pass++;
      n_checks++; if (len_ll !== 6'd20) $display("FAIL full_len: got %0d want 20", len_ll); else n_pass++;
      n_checks++; if (inprog_ll !== 1'b0 || trunc_ll !== 1'b0) $display("FAIL full_end: got inprog %0b trunc %0b want 0 0", inprog_ll, trunc_ll); else n_pass++;
   endtask

   task automatic test_drop_full();
      bit f;
      int fires, bad, t;
      sel = 1'b1; st_ready_dr = 1'b0; rx_dr.delete(); n_trunc = 0; fires = 0; bad = 0; t = 0;
      for (int i = 0; i < 20; i++) begin
         put_beat(4, i, 20, 1'b1, 0, f);
         if (f) fires++;
         if (i == 18) begin
            n_checks++; if ({sid_dr, sdata_dr, sresp_dr, slast_dr, suser_dr, svalid_dr, rready_dr} !==
                            {32'(4), bdata(4, 18), 2'(18), 1'b0, 64'(4 * 256 + 18), 1'b1, 1'b1})
               $display("FAIL drop_fwd: got data %0h want %0h", sdata_dr, bdata(4, 18)); else n_pass++;
         end
      end
      m_valid = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (fires !== 20) $display("FAIL drop_nostall: got %0d want 20", fires); else n_pass++;
      n_checks++; if (n_trunc !== 1) $display("FAIL drop_trunc_pulses: got %0d want 1", n_trunc); else n_pass++;
      n_checks++; if (len_dr !== 6'd16) $display("FAIL drop_len: got %0d want 16", len_dr); else n_pass++;
      st_ready_dr = 1'b1;
      while (rx_dr.size() < 16 && t < 40) begin @(negedge clk); t++; end
      repeat (3) @(negedge clk);
      for (int k = 0; k < rx_dr.size(); k++)
         if (rx_dr[k] !== {bdata(4, k), (k == 15)}) bad++;
      n_checks++; if (rx_dr.size() !== 16) $display("FAIL drop_count: got %0d want 16", rx_dr.size()); else n_pass++;
      n_checks++; if (bad !== 0) $display("FAIL drop_entries: got %0d bad entries want 0", bad); else n_pass++;
      n_checks++; if (valid_dr !== 1'b0 || inprog_dr !== 1'b0) $display("FAIL drop_end: got valid %0b inprog %0b want 0 0", valid_dr, inprog_dr); else n_pass++;
      sel = 1'b0;
   endtask

   task automatic test_saturate();
      bit f;
      int fires;
      sel = 1'b0; st_ready_ll = 1'b1; fires = 0;
      for (int i = 0; i < 70; i++) begin
         put_beat(5, i, 70, 1'b1, 0, f);
         if (f) fires++;
      end
      m_valid = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (fires !== 70) $display("FAIL sat_fires: got %0d want 70", fires); else n_pass++;
      n_checks++; if (len_ll !== 6'd63) $display("FAIL sat_len: got %0d want 63", len_ll); else n_pass++;
      for (int i = 0; i < 2; i++) put_beat(6, i, 2, 1'b1, 0, f);
      m_valid = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (len_ll !== 6'd2) $display("FAIL sat_next_len: got %0d want 2", len_ll); else n_pass++;
   endtask

   task automatic test_reset_mid();
      bit f;
      int bad, t;
      sel = 1'b0; st_ready_ll = 1'b0; bad = 0; t = 0;
      for (int i = 0; i < 3; i++) put_beat(7, i, 8, 1'b1, 0, f);
      n_checks++; if (valid_ll !== 1'b1 || inprog_ll !== 1'b1) $display("FAIL mid_prefill: got valid %0b inprog %0b want 1 1", valid_ll, inprog_ll); else n_pass++;
      m_valid = 1'b0; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_checks++; if (valid_ll !== 1'b0) $display("FAIL mid_valid: got %0b want 0", valid_ll); else n_pass++;
      n_checks++; if (inprog_ll !== 1'b0) $display("FAIL mid_inprog: got %0b want 0", inprog_ll); else n_pass++;
      n_checks++; if (len_ll !== 6'd0) $display("FAIL mid_len: got %0d want 0", len_ll); else n_pass++;
      rx_ll.delete(); st_ready_ll = 1'b1;
      for (int i = 0; i < 3; i++) put_beat(8, i, 3, 1'b1, 0, f);
      m_valid = 1'b0;
      while (rx_ll.size() < 3 && t < 20) begin @(negedge clk); t++; end
      repeat (2) @(negedge clk);
      for (int k = 0; k < rx_ll.size(); k++)
         if (rx_ll[k] !== {bdata(8, k), (k == 2)}) bad++;
      n_checks++; if (rx_ll.size() !== 3 || bad !== 0) $display("FAIL mid_retap: got %0d entries %0d bad want 3 0", rx_ll.size(), bad); else n_pass++;
      n_checks++; if (len_ll !== 6'd3) $display("FAIL mid_retap_len: got %0d want 3", len_ll); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic_tap();
      test_no_tap();
      test_lossless_full();
      test_drop_full();
      test_saturate();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
      $fatal(1, "watchdog");
   end

endmodule
